// File: rtl/uart_rx_deframer_if.sv
// ---------------------------------------------------------------------------
// uart_rx_deframer_if
// Byte-delivery handshake between the serial receiver and its consumer.
//   out_data   received byte, stable while out_valid = 1 (driven by master)
//   out_valid  byte available, held until accepted         (driven by master)
//   out_ready  consumer accepts when out_valid & out_ready (driven by slave)
// master = the receiver, slave = the consumer.
// ---------------------------------------------------------------------------
interface uart_rx_deframer_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/uart_rx_deframer.sv
// ---------------------------------------------------------------------------
// uart_rx_deframer
// Asynchronous 8N1-style serial receiver (LSB first, idle high). Turns the
// rxd line into parallel bytes offered on a valid/ready handshake, rejecting
// short start-bit glitches and reporting framing errors and overruns.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   rxd        raw serial input, asynchronous to clk, idle = 1
//   out_if     byte handshake (master side): out_data / out_valid / out_ready
//   frame_err  1-cycle pulse when the stop bit is sampled as 0
//   overrun    1-cycle pulse when a byte completes while the previous one is
//              still unaccepted (the new byte is dropped)
//   busy       1 whenever the receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx_deframer #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int DATA_BITS    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rxd,
    uart_rx_deframer_if.master  out_if,
    output logic                frame_err,
    output logic                overrun,
    output logic                busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t               state;
    logic                 rx_meta;
    logic                 rxs;
    logic                 rxs_prev;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        idx;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] out_data_q;
    logic                 out_valid_q;

    assign out_if.out_data  = out_data_q;
    assign out_if.out_valid = out_valid_q;

    // Two-flop synchroniser for the asynchronous line, plus one more flop of
    // history so the idle state can spot a 1->0 transition on the clean
    // signal. All three reset to the idle level so release never looks like
    // a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta  <= 1'b1;
            rxs      <= 1'b1;
            rxs_prev <= 1'b1;
        end else begin
            rx_meta  <= rxd;
            rxs      <= rx_meta;
            rxs_prev <= rxs;
        end
    end

    // Frame state machine with registered outputs. The start bit is checked
    // at its midpoint, then every following sample lands one full bit period
    // later, i.e. in the middle of each data bit and of the stop bit.
    // Returning to IDLE at mid-stop leaves half a bit of slack so a
    // back-to-back start edge is never missed. A stop bit of 0 parks the
    // machine in BREAK until the line goes high again, so a held-low line
    // cannot retrigger frames. The handshake clear is written first so a
    // delivery on the same edge overrides it and keeps out_valid high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            cnt         <= '0;
            idx         <= '0;
            shift       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            frame_err   <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;

            if (out_valid_q && out_if.out_ready) begin
                out_valid_q <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (rxs_prev && !rxs) begin
                        state <= START;
                        busy  <= 1'b1;
                        cnt   <= '0;
                    end
                end

                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt <= '0;
                        if (!rxs) begin
                            state <= DATA;
                            idx   <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt        <= '0;
                        shift[idx] <= rxs;
                        if (idx == IDX_LAST) begin
                            state <= STOP;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (rxs) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            if (!out_valid_q || out_if.out_ready) begin
                                out_data_q  <= shift;
                                out_valid_q <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                BREAK: begin
                    if (rxs) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_deframer
// Directed bench for uart_rx_deframer with CLKS_PER_BIT=16, DATA_BITS=8.
// Stimulus pushes expected bytes into a scoreboard queue; an independent
// monitor pops and compares every accepted byte and tallies flag pulses.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx_deframer;

    localparam int CLKS = 16;

    logic clk;
    logic rst;
    logic rxd;
    logic frame_err;
    logic overrun;
    logic busy;

    uart_rx_deframer_if #(.DATA_BITS(8)) out_if ();

    uart_rx_deframer #(
        .CLKS_PER_BIT(CLKS),
        .DATA_BITS   (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rxd      (rxd),
        .out_if   (out_if.master),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    int          errors;
    int          checks;
    int          cycle;
    int          fall_cycle;
    int          valid_rise_cycle;
    int          fe_count;
    int          ov_count;
    int          valid_count;
    logic        prev_valid;
    logic [7:0]  exp_q[$];

    // Free-running clock and cycle counter used for latency measurement.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Single comparison point: every check goes through here.
    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Serial transmitter: start bit, DATA bits LSB first, then the given stop
    // level. Records the cycle on which the start edge was driven.
    task automatic apply_stimulus(input logic [7:0] data, input logic stop_bit);
        rxd = 1'b0;
        fall_cycle = cycle;
        repeat (CLKS) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rxd = data[i];
            repeat (CLKS) @(posedge clk);
            #1;
        end
        rxd = stop_bit;
        repeat (CLKS) @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: samples on the falling edge, scores accepted bytes against the
    // queue, and counts valid rises and flag pulses.
    always @(negedge clk) begin
        if (rst) begin
            if (out_if.out_valid && !prev_valid) begin
                valid_rise_cycle = cycle;
                valid_count++;
            end
            if (frame_err) fe_count++;
            if (overrun)   ov_count++;
            if (out_if.out_valid && out_if.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_byte: got %0h expected none", out_if.out_data);
                end else begin
                    check_output("rx_byte", {24'h0, out_if.out_data}, {24'h0, exp_q.pop_front()});
                end
            end
        end
        prev_valid = out_if.out_valid;
    end

    initial begin
        int fe0, ov0, vc0;
        errors = 0; checks = 0; cycle = 0; fall_cycle = 0; valid_rise_cycle = 0;
        fe_count = 0; ov_count = 0; valid_count = 0; prev_valid = 1'b0;
        rst = 1'b0;
        rxd = 1'b1;
        out_if.out_ready = 1'b1;

        // Test 1: reset with a toggling line, then release.
        @(posedge clk);
        #1;
        for (int i = 0; i < 20; i++) begin
            rxd = ~rxd;
            wait_cycles(1);
        end
        rxd = 1'b1;
        wait_cycles(3);
        check_output("reset_valid", {31'h0, out_if.out_valid}, 32'h0);
        check_output("reset_data", {24'h0, out_if.out_data}, 32'h0);
        check_output("reset_frame_err", {31'h0, frame_err}, 32'h0);
        check_output("reset_overrun", {31'h0, overrun}, 32'h0);
        check_output("reset_busy", {31'h0, busy}, 32'h0);
        rst = 1'b1;
        wait_cycles(20);
        check_output("post_reset_busy", {31'h0, busy}, 32'h0);
        check_output("post_reset_valid_count", valid_count, 32'd0);

        // Test 2: clean frame 0xA5 and its latency.
        fe0 = fe_count; ov0 = ov_count; vc0 = valid_count;
        exp_q.push_back(8'hA5);
        apply_stimulus(8'hA5, 1'b1);
        wait_cycles(5);
        check_output("a5_latency", valid_rise_cycle - fall_cycle, 32'd155);
        check_output("a5_valid_count", valid_count - vc0, 32'd1);
        check_output("a5_frame_err", fe_count - fe0, 32'd0);
        check_output("a5_overrun", ov_count - ov0, 32'd0);
        check_output("a5_queue_empty", exp_q.size(), 32'd0);
        check_output("a5_valid_cleared", {31'h0, out_if.out_valid}, 32'h0);

        // Test 3: 5-cycle low glitch on an idle line.
        vc0 = valid_count;
        rxd = 1'b0;
        wait_cycles(4);
        check_output("glitch_busy_start", {31'h0, busy}, 32'h1);
        wait_cycles(1);
        rxd = 1'b1;
        wait_cycles(20);
        check_output("glitch_busy_idle", {31'h0, busy}, 32'h0);
        check_output("glitch_no_valid", valid_count - vc0, 32'd0);

        // Test 4: bad stop bit, held-low break, then a good frame.
        fe0 = fe_count; ov0 = ov_count; vc0 = valid_count;
        apply_stimulus(8'h3C, 1'b0);
        wait_cycles(40);
        check_output("break_frame_err", fe_count - fe0, 32'd1);
        check_output("break_busy", {31'h0, busy}, 32'h1);
        check_output("break_no_valid", valid_count - vc0, 32'd0);
        rxd = 1'b1;
        wait_cycles(10);
        check_output("break_exit_busy", {31'h0, busy}, 32'h0);
        exp_q.push_back(8'h55);
        apply_stimulus(8'h55, 1'b1);
        wait_cycles(5);
        check_output("x55_queue_empty", exp_q.size(), 32'd0);
        check_output("x55_valid_count", valid_count - vc0, 32'd1);
        check_output("x55_frame_err", fe_count - fe0, 32'd1);
        check_output("x55_overrun", ov_count - ov0, 32'd0);

        // Test 5: consumer stalled, two back-to-back frames -> overrun.
        fe0 = fe_count; ov0 = ov_count; vc0 = valid_count;
        out_if.out_ready = 1'b0;
        exp_q.push_back(8'h11);
        apply_stimulus(8'h11, 1'b1);
        apply_stimulus(8'h22, 1'b1);
        wait_cycles(5);
        check_output("ovr_pulse", ov_count - ov0, 32'd1);
        check_output("ovr_frame_err", fe_count - fe0, 32'd0);
        check_output("ovr_valid_held", {31'h0, out_if.out_valid}, 32'h1);
        check_output("ovr_data_held", {24'h0, out_if.out_data}, 32'h11);
        out_if.out_ready = 1'b1;
        wait_cycles(20);
        check_output("ovr_valid_dropped", {31'h0, out_if.out_valid}, 32'h0);
        check_output("ovr_queue_empty", exp_q.size(), 32'd0);
        check_output("ovr_valid_count", valid_count - vc0, 32'd1);

        // Test 6: reset in the middle of a frame, then a clean frame.
        rxd = 1'b0;
        wait_cycles(CLKS);
        rxd = 1'b1;
        wait_cycles(3 * CLKS);
        check_output("midframe_busy", {31'h0, busy}, 32'h1);
        rst = 1'b0;
        #1;
        check_output("midreset_busy", {31'h0, busy}, 32'h0);
        check_output("midreset_valid", {31'h0, out_if.out_valid}, 32'h0);
        wait_cycles(3);
        rst = 1'b1;
        wait_cycles(20);
        fe0 = fe_count; ov0 = ov_count; vc0 = valid_count;
        exp_q.push_back(8'h0F);
        apply_stimulus(8'h0F, 1'b1);
        wait_cycles(5);
        check_output("x0f_queue_empty", exp_q.size(), 32'd0);
        check_output("x0f_valid_count", valid_count - vc0, 32'd1);
        check_output("x0f_frame_err", fe_count - fe0, 32'd0);
        check_output("x0f_overrun", ov_count - ov0, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
